vote_display_ctrl: RTL and testbench

Parametrised mode and display controller for the voting machine. It sits between the per-candidate vote counters and the LED bank. In voting mode it flashes an acknowledge pattern for a programmable number of cycles after each valid vote. In result mode it performs a sequential winner/tie scan over N candidates and shows a selected candidate's count on the LEDs.

---
 rtl/vote_pkg.sv | 14 +
 rtl/vote_max_scan.sv | 72 +++++++
 rtl/vote_display_ctrl.sv | 120 ++++++++++++
 tb/tb_vote_display_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and width helpers for the voting-machine display controller.
package vote_pkg;

  typedef enum logic [1:0] {IDLE, ACK, SCAN, SHOW} state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ack_cnt_w(input int c);
    return $clog2(c + 1);
  endfunction

endpackage

// File: rtl/vote_max_scan.sv
// Sequential max/tie scanner: visits one candidate per cycle after start.
// done, winner_idx and tie are valid together in the cycle of the last visit.
module vote_max_scan
  import vote_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int VOTE_W   = 8,
  localparam int IDX_W   = idx_w(NUM_CAND)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CAND*VOTE_W-1:0] vote_counts,
  output logic                       done,
  output logic [IDX_W-1:0]           winner_idx,
  output logic                       tie
);

  logic [VOTE_W-1:0] cnt_a [NUM_CAND];
  logic              busy_q;
  logic [IDX_W-1:0]  idx_q, win_q, win_d;
  logic [VOTE_W-1:0] max_q, max_d, cur;
  logic              tie_q, tie_d, last;

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_cnt
    assign cnt_a[i] = vote_counts[i*VOTE_W +: VOTE_W];
  end

  // Live count of the visited index; no snapshot of vote_counts is taken.
  assign cur  = cnt_a[idx_q];
  assign last = (idx_q == IDX_W'(NUM_CAND - 1));

  always_comb begin
    max_d = max_q;
    win_d = win_q;
    tie_d = tie_q;
    if (cur > max_q) begin
      max_d = cur;
      win_d = idx_q;
      tie_d = 1'b0;
    end else if (cur == max_q && idx_q != '0) begin
      tie_d = 1'b1;
    end
  end

  assign done       = busy_q && last;
  assign winner_idx = win_d;
  assign tie        = tie_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      max_q  <= '0;
      win_q  <= '0;
      tie_q  <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      idx_q  <= '0;
      max_q  <= '0;
      win_q  <= '0;
      tie_q  <= 1'b0;
    end else if (busy_q) begin
      max_q <= max_d;
      win_q <= win_d;
      tie_q <= tie_d;
      if (last) busy_q <= 1'b0;
      else      idx_q  <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vote_display_ctrl.sv
// Mode/display controller: acknowledge flash in voting mode, winner scan and
// per-candidate count display in result mode.
module vote_display_ctrl
  import vote_pkg::*;
#(
  parameter int NUM_CAND   = 4,
  parameter int VOTE_W     = 8,
  parameter int LED_W      = 8,
  parameter int ACK_CYCLES = 10,
  localparam int IDX_W     = idx_w(NUM_CAND)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       valid_vote_casted,
  input  logic [NUM_CAND*VOTE_W-1:0] vote_counts,
  input  logic [NUM_CAND-1:0]        cand_button,
  output logic [LED_W-1:0]           leds,
  output logic                       ack_busy,
  output logic                       result_valid,
  output logic [IDX_W-1:0]           winner_idx,
  output logic                       tie
);

  localparam int CNT_W = ack_cnt_w(ACK_CYCLES);

  state_e           state_q;
  logic             mode_q;
  logic [CNT_W-1:0] ack_cnt_q;
  logic [LED_W-1:0] leds_q;
  logic             ack_busy_q, rv_q, tie_q;
  logic [IDX_W-1:0] win_q;

  logic             rise, btn_hit;
  logic [LED_W-1:0] btn_led;
  logic             scan_done, scan_tie;
  logic [IDX_W-1:0] scan_win;

  assign rise = mode & ~mode_q;

  // Walk from the top index down so the lowest pressed button wins.
  always_comb begin
    btn_hit = |cand_button;
    btn_led = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--)
      if (cand_button[i]) btn_led = LED_W'(vote_counts[i*VOTE_W +: VOTE_W]);
  end

  vote_max_scan #(.NUM_CAND(NUM_CAND), .VOTE_W(VOTE_W)) u_scan (
    .clk        (clock),
    .rst        (reset),
    .start      (rise),
    .vote_counts(vote_counts),
    .done       (scan_done),
    .winner_idx (scan_win),
    .tie        (scan_tie)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      ack_cnt_q  <= '0;
      leds_q     <= '0;
      ack_busy_q <= 1'b0;
      rv_q       <= 1'b0;
      win_q      <= '0;
      tie_q      <= 1'b0;
    end else begin
      mode_q <= mode;
      if (rise) begin
        state_q    <= SCAN;
        leds_q     <= '0;
        rv_q       <= 1'b0;
        ack_busy_q <= 1'b0;
        ack_cnt_q  <= '0;
      end else if (!mode && (state_q == SCAN || state_q == SHOW)) begin
        // winner/tie deliberately kept for inspection after leaving result mode
        state_q <= IDLE;
        leds_q  <= '0;
        rv_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (!mode && valid_vote_casted) begin
            state_q    <= ACK;
            ack_cnt_q  <= CNT_W'(1);
            leds_q     <= '1;
            ack_busy_q <= 1'b1;
          end
          ACK: begin
            if (valid_vote_casted) begin
              ack_cnt_q <= CNT_W'(1);
            end else if (ack_cnt_q == CNT_W'(ACK_CYCLES)) begin
              state_q    <= IDLE;
              leds_q     <= '0;
              ack_busy_q <= 1'b0;
            end else begin
              ack_cnt_q <= ack_cnt_q + CNT_W'(1);
            end
          end
          SCAN: if (scan_done) begin
            state_q <= SHOW;
            win_q   <= scan_win;
            tie_q   <= scan_tie;
            rv_q    <= 1'b1;
          end
          SHOW: if (btn_hit) leds_q <= btn_led;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign leds         = leds_q;
  assign ack_busy     = ack_busy_q;
  assign result_valid = rv_q;
  assign winner_idx   = win_q;
  assign tie          = tie_q;

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Randomized self-checking bench for vote_display_ctrl against a rule-level model.
module tb_vote_display_ctrl;
  localparam int N   = 4;
  localparam int VW  = 10;
  localparam int LW  = 8;
  localparam int ACK = 10;

  logic            clock = 1'b0;
  logic            reset, mode, vote;
  logic [N*VW-1:0] counts;
  logic [N-1:0]    btn;
  logic [LW-1:0]   leds;
  logic            ack_busy, result_valid, tie;
  logic [1:0]      winner_idx;

  int errs = 0, checks = 0;
  int rem = 0, ons = 0, shown = 0;
  int cnt_m [N];
  int win_m = 0;
  bit tie_m = 0;

  vote_display_ctrl #(.NUM_CAND(N), .VOTE_W(VW), .LED_W(LW), .ACK_CYCLES(ACK)) dut (
    .clock(clock), .reset(reset), .mode(mode), .valid_vote_casted(vote),
    .vote_counts(counts), .cand_button(btn), .leds(leds), .ack_busy(ack_busy),
    .result_valid(result_valid), .winner_idx(winner_idx), .tie(tie)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input int b, input int c, input int d);
    cnt_m[0] = a; cnt_m[1] = b; cnt_m[2] = c; cnt_m[3] = d;
    for (int i = 0; i < N; i++) counts[i*VW +: VW] = VW'(cnt_m[i]);
  endtask

  // Winner: lowest index holding the maximum; tie: maximum held by two or more.
  task automatic ref_scan();
    int mx, n;
    mx = -1; n = 0;
    for (int i = 0; i < N; i++) if (cnt_m[i] > mx) begin mx = cnt_m[i]; win_m = i; end
    for (int i = 0; i < N; i++) if (cnt_m[i] == mx) n++;
    tie_m = (n >= 2);
  endtask

  // One voting-mode cycle: flash lasts ACK cycles from the most recent vote.
  task automatic vcyc(input bit v);
    vote = v;
    @(posedge clock);
    if (v) rem = ACK; else if (rem > 0) rem--;
    @(negedge clock);
    vote = 1'b0;
    if (leds == 8'hFF) ons++;
    chk("ack_leds", leds, (rem > 0) ? 32'hFF : 32'h0);
    chk("ack_busy", ack_busy, (rem > 0) ? 32'h1 : 32'h0);
  endtask

  // Called with mode already high at a negedge; the next edge samples the rise.
  task automatic scan_wait(input string tag);
    ref_scan();
    shown = 0; rem = 0;
    for (int k = 0; k < N; k++) begin
      btn = (k == 1) ? N'($urandom_range(1, 15)) : '0;
      @(negedge clock);
    end
    btn = '0;
    chk({tag, "_rv_early"}, result_valid, 0);
    @(negedge clock);
    chk({tag, "_rv"}, result_valid, 1);
    chk({tag, "_win"}, winner_idx, win_m);
    chk({tag, "_tie"}, tie, tie_m);
    chk({tag, "_leds"}, leds, 0);
  endtask

  task automatic do_scan(input string tag);
    mode = 1'b1;
    scan_wait(tag);
  endtask

  task automatic press(input logic [N-1:0] b, input string tag);
    btn = b;
    @(negedge clock);
    btn = '0;
    for (int i = N - 1; i >= 0; i--) if (b[i]) shown = cnt_m[i] & 'hFF;
    chk(tag, leds, shown);
  endtask

  task automatic exit_show();
    mode = 1'b0;
    @(negedge clock);
    chk("exit_leds", leds, 0);
    chk("exit_rv", result_valid, 0);
    chk("exit_win", winner_idx, win_m);
    chk("exit_tie", tie, tie_m);
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; vote = 1'b0; btn = '0; counts = '0;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    #12;
    chk("rst_leds", leds, 0);
    chk("rst_busy", ack_busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_win", winner_idx, 0);
    chk("rst_tie", tie, 0);
    @(negedge clock);
    reset = 1'b0;

    ons = 0;
    vcyc(1'b1);
    repeat (14) vcyc(1'b0);
    chk("flash_len", ons, ACK);

    ons = 0;
    vcyc(1'b1);
    repeat (4) vcyc(1'b0);
    vcyc(1'b1);
    repeat (14) vcyc(1'b0);
    chk("retrig_len", ons, 15);

    repeat (80) vcyc($urandom_range(0, 7) == 0);

    load(3, 9, 9, 2);
    do_scan("tie");
    press(4'b1100, "btn_prio");
    repeat (3) begin
      @(negedge clock);
      chk("btn_hold", leds, shown);
    end
    vote = 1'b1;
    @(negedge clock);
    vote = 1'b0;
    chk("res_vote_busy", ack_busy, 0);
    chk("res_vote_leds", leds, shown);
    exit_show();

    load(3, 9, 7, 2);
    do_scan("notie");
    exit_show();

    load(0, 0, 0, 0);
    do_scan("zero");
    exit_show();

    load('h3A5, 5, 'h100, 7);
    do_scan("wide");
    press(4'b0001, "trunc");
    press(4'b0100, "trunc_hi");
    exit_show();

    for (int r = 0; r < 8; r++) begin
      if (r[0]) load($urandom_range(0, 1023), $urandom_range(0, 1023),
                     $urandom_range(0, 1023), $urandom_range(0, 1023));
      else      load($urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
      do_scan("rnd");
      repeat (3) press(N'($urandom_range(1, 15)), "rnd_btn");
      exit_show();
    end

    load(1, 2, 3, 4);
    mode = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_leds", leds, 0);
    chk("midrst_rv", result_valid, 0);
    chk("midrst_win", winner_idx, 0);
    chk("midrst_tie", tie, 0);
    chk("midrst_busy", ack_busy, 0);
    @(negedge clock);
    reset = 1'b0;
    scan_wait("after_rst");
    exit_show();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
